// File: rtl/da_cache_pkg.sv
// Shared types and widths for the ping-pong DAC sample cache.
`ifndef DA_CACHE_GLOBALS_SVH
`include "globals.sv"
`endif

package da_cache_pkg;

    localparam int WORD_NBIT       = `USB_DATA_NBIT;
    localparam int WORDS_PER_ENTRY = 3;
    localparam int ENTRY_NBIT      = WORDS_PER_ENTRY * WORD_NBIT;
    localparam int LANE_NBIT       = ENTRY_NBIT / 2;
    localparam int SYNC_NFLOP      = 3;
    localparam int PACK_NBIT       = 2;

    typedef enum logic [PACK_NBIT-1:0] {
        PACK_W0 = 2'd0,
        PACK_W1 = 2'd1,
        PACK_W2 = 2'd2
    } pack_state_e;

    // Lane 0 is the upper half of an entry, lane 1 the lower half.
    function automatic logic [LANE_NBIT-1:0] entry_lane(
        input logic [ENTRY_NBIT-1:0] entry,
        input logic                  sel
    );
        return sel ? entry[LANE_NBIT-1:0] : entry[ENTRY_NBIT-1:LANE_NBIT];
    endfunction

endpackage

// File: rtl/da_cache_ram.sv
// Simple dual-port RAM: port A writes, port B reads with one cycle of latency.
module buffered_ram_tdp #(
    parameter int AW = 1,
    parameter int DW = 1
) (
    input  logic          clk,
    input  logic          a_we_i,
    input  logic [AW-1:0] a_addr_i,
    input  logic [DW-1:0] a_din_i,
    input  logic          b_re_i,
    input  logic [AW-1:0] b_addr_i,
    output logic [DW-1:0] b_dout_o
);

    logic [DW-1:0] mem_q [0:(1 << AW) - 1];
    logic [DW-1:0] b_dout_q;

    // Contents are intentionally not reset; the full flags guard stale reads.
    always_ff @(posedge clk) begin
        if (a_we_i) begin
            mem_q[a_addr_i] <= a_din_i;
        end
        if (b_re_i) begin
            b_dout_q <= mem_q[b_addr_i];
        end
    end

    assign b_dout_o = b_dout_q;

endmodule

// File: rtl/globals.sv
// Project-wide widths shared by the DAC cache and the host interface.
`ifndef DA_CACHE_GLOBALS_SVH
`define DA_CACHE_GLOBALS_SVH
`define DA_CHE_ADDR_NBIT 9
`define DA_DATA_NBIT 16
`define USB_DATA_NBIT 16
`endif

// File: rtl/da_cache.sv
// Ping-pong cache between a 16-bit host word stream and a DAC sample stream:
// host words are packed three per RAM entry, each entry yields two samples.
`ifndef DA_CACHE_GLOBALS_SVH
`include "globals.sv"
`endif

module da_cache
    import da_cache_pkg::*;
#(
    parameter int ADDR_NBIT = `DA_CHE_ADDR_NBIT,
    parameter int DA_NBIT   = `DA_DATA_NBIT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 sync,
    input  logic                 wr,
    input  logic [WORD_NBIT-1:0] wdata,
    output logic                 wready,
    input  logic                 sp_req,
    output logic [DA_NBIT-1:0]   dout,
    output logic                 dvalid,
    output logic                 switch,
    output logic                 underrun,
    output logic                 overflow,
    output logic [PACK_NBIT-1:0] pack_state_o
);

    localparam int                    RAM_AW     = ADDR_NBIT + 1;
    localparam logic [ADDR_NBIT-1:0]  IDX_LAST   = '1;
    localparam int                    DOUT_SHIFT = LANE_NBIT - DA_NBIT;

    // Handshake: a host word transfers on a cycle where wr and wready are both
    // high; wr without wready is dropped and flagged in overflow. sp_req is a
    // single-cycle request that always produces exactly one dvalid pulse two
    // cycles later, carrying either a sample or zero.

    logic [SYNC_NFLOP-1:0]  sync_q, sync_d;
    pack_state_e            pack_q, pack_d;
    logic [WORD_NBIT-1:0]   word0_q, word0_d, word1_q, word1_d;
    logic [ENTRY_NBIT-1:0]  entry_q, entry_d;
    logic                   wpend_q, wpend_d;
    logic [ADDR_NBIT-1:0]   widx_q, widx_d;
    logic                   wbank_q, wbank_d;
    logic [1:0]             full_q, full_d;
    logic [ADDR_NBIT-1:0]   ridx_q, ridx_d;
    logic                   rbank_q, rbank_d;
    logic                   lane_q, lane_d;
    logic                   rd_v_q, rd_v_d;
    logic                   rd_ok_q, rd_ok_d;
    logic                   rd_lane_q, rd_lane_d;
    logic [DA_NBIT-1:0]     dout_q, dout_d;
    logic                   dvalid_q, dvalid_d;
    logic                   underrun_q, underrun_d;
    logic                   overflow_q, overflow_d;

    logic                   restart;
    logic                   wtarget;
    logic                   wready_c;
    logic                   accept;
    logic                   serve;
    logic                   starve;
    logic                   ram_we;
    logic [ENTRY_NBIT-1:0]  ram_rdata;
    logic [LANE_NBIT-1:0]   rd_lane_data;

    assign restart  = sync_q[SYNC_NFLOP-2] & ~sync_q[SYNC_NFLOP-1];

    // A pending write to the last index moves the writer to the other bank,
    // so the next word must be checked against that bank's full flag.
    assign wtarget  = wbank_q ^ (wpend_q & (widx_q == IDX_LAST));
    assign wready_c = en & ~restart & ~full_q[wtarget];
    assign accept   = wr & wready_c;
    assign serve    = sp_req & en & ~restart & full_q[rbank_q];
    assign starve   = sp_req & en & ~restart & ~full_q[rbank_q];
    assign ram_we   = wpend_q & ~restart;

    buffered_ram_tdp #(
        .AW (RAM_AW),
        .DW (ENTRY_NBIT)
    ) u_ram (
        .clk      (clk),
        .a_we_i   (ram_we),
        .a_addr_i ({wbank_q, widx_q}),
        .a_din_i  (entry_q),
        .b_re_i   (serve),
        .b_addr_i ({rbank_q, ridx_q}),
        .b_dout_o (ram_rdata)
    );

    assign rd_lane_data = entry_lane(ram_rdata, rd_lane_q);

    always_comb begin
        sync_d     = {sync_q[SYNC_NFLOP-2:0], sync};
        pack_d     = pack_q;
        word0_d    = word0_q;
        word1_d    = word1_q;
        entry_d    = entry_q;
        wpend_d    = 1'b0;
        widx_d     = widx_q;
        wbank_d    = wbank_q;
        full_d     = full_q;
        ridx_d     = ridx_q;
        rbank_d    = rbank_q;
        lane_d     = lane_q;
        rd_v_d     = sp_req;
        rd_ok_d    = serve;
        rd_lane_d  = lane_q;
        dout_d     = dout_q;
        dvalid_d   = rd_v_q;
        underrun_d = underrun_q | starve;
        overflow_d = overflow_q | (wr & ~wready_c & ~restart);

        if (wpend_q) begin
            widx_d = widx_q + 1'b1;
            if (widx_q == IDX_LAST) begin
                full_d[wbank_q] = 1'b1;
                wbank_d         = ~wbank_q;
            end
        end

        if (accept) begin
            case (pack_q)
                PACK_W0: begin
                    word0_d = wdata;
                    pack_d  = PACK_W1;
                end
                PACK_W1: begin
                    word1_d = wdata;
                    pack_d  = PACK_W2;
                end
                PACK_W2: begin
                    entry_d = {word0_q, word1_q, wdata};
                    wpend_d = 1'b1;
                    pack_d  = PACK_W0;
                end
                default: pack_d = PACK_W0;
            endcase
        end

        // Reader clear and writer set always target different banks.
        if (serve) begin
            lane_d = ~lane_q;
            if (lane_q) begin
                ridx_d = ridx_q + 1'b1;
                if (ridx_q == IDX_LAST) begin
                    full_d[rbank_q] = 1'b0;
                    rbank_d         = ~rbank_q;
                end
            end
        end

        if (rd_v_q) begin
            dout_d = rd_ok_q ? DA_NBIT'(rd_lane_data >> DOUT_SHIFT) : '0;
        end

        if (restart) begin
            pack_d     = PACK_W0;
            wpend_d    = 1'b0;
            widx_d     = '0;
            wbank_d    = 1'b0;
            full_d     = '0;
            ridx_d     = '0;
            rbank_d    = 1'b0;
            lane_d     = 1'b0;
            underrun_d = 1'b0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            pack_q     <= PACK_W0;
            word0_q    <= '0;
            word1_q    <= '0;
            entry_q    <= '0;
            wpend_q    <= 1'b0;
            widx_q     <= '0;
            wbank_q    <= 1'b0;
            full_q     <= '0;
            ridx_q     <= '0;
            rbank_q    <= 1'b0;
            lane_q     <= 1'b0;
            rd_v_q     <= 1'b0;
            rd_ok_q    <= 1'b0;
            rd_lane_q  <= 1'b0;
            dout_q     <= '0;
            dvalid_q   <= 1'b0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            pack_q     <= pack_d;
            word0_q    <= word0_d;
            word1_q    <= word1_d;
            entry_q    <= entry_d;
            wpend_q    <= wpend_d;
            widx_q     <= widx_d;
            wbank_q    <= wbank_d;
            full_q     <= full_d;
            ridx_q     <= ridx_d;
            rbank_q    <= rbank_d;
            lane_q     <= lane_d;
            rd_v_q     <= rd_v_d;
            rd_ok_q    <= rd_ok_d;
            rd_lane_q  <= rd_lane_d;
            dout_q     <= dout_d;
            dvalid_q   <= dvalid_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
        end
    end

    // wready is combinational, so it is forced low while reset is held.
    assign wready       = wready_c & rst_n;
    assign dout         = dout_q;
    assign dvalid       = dvalid_q;
    assign switch       = rbank_q;
    assign underrun     = underrun_q;
    assign overflow     = overflow_q;
    assign pack_state_o = pack_q;

endmodule

// File: tb/tb_da_cache.sv
// Bench for da_cache with 4 entries per bank and 16-bit samples.
module tb_da_cache;

    localparam int AW = 2;
    localparam int DW = 16;
    localparam int D  = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          sync = 1'b0;
    logic          wr = 1'b0;
    logic [15:0]   wdata = '0;
    logic          sp_req = 1'b0;
    logic          wready;
    logic [DW-1:0] dout;
    logic          dvalid;
    logic          sw;
    logic          underrun;
    logic          overflow;
    logic [1:0]    pack_state;

    da_cache #(
        .ADDR_NBIT (AW),
        .DA_NBIT   (DW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .sync         (sync),
        .wr           (wr),
        .wdata        (wdata),
        .wready       (wready),
        .sp_req       (sp_req),
        .dout         (dout),
        .dvalid       (dvalid),
        .switch       (sw),
        .underrun     (underrun),
        .overflow     (overflow),
        .pack_state_o (pack_state)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fails  = 0;
    int          cyc      = 0;

    // Behavioural model: everything is counted since the last restart.
    int          acc_words;
    int          ent_wr;
    int          smp_rd;
    bit          pend;
    logic [47:0] pend_val;
    logic [15:0] wbuf[$];
    logic [47:0] ents[$];
    bit          m_under;
    bit          m_over;
    bit   [2:0]  hist;
    logic [DW-1:0] exp_q[$];
    int          exp_t[$];
    logic [DW-1:0] got_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit m_restart();
        return hist[1] & ~hist[2];
    endfunction

    function automatic int banks_read();
        return (smp_rd / 2) / D;
    endfunction

    function automatic bit m_wready();
        return rst_n && en && !m_restart() && !(((acc_words / 3) / D) - banks_read() >= 2);
    endfunction

    task automatic clear_data();
        acc_words = 0;
        ent_wr    = 0;
        smp_rd    = 0;
        pend      = 1'b0;
        wbuf.delete();
        ents.delete();
        m_under   = 1'b0;
        m_over    = 1'b0;
    endtask

    task automatic model_step();
        bit          rs;
        bit          ok_w;
        bit          have;
        logic [47:0] e;
        logic [23:0] ln;
        cyc++;
        rs   = m_restart();
        ok_w = m_wready();
        have = (ent_wr / D) > banks_read();
        if (sp_req) begin
            if (en && !rs && have) begin
                e  = ents[smp_rd / 2];
                ln = (smp_rd % 2 == 0) ? e[47:24] : e[23:0];
                exp_q.push_back(ln[23:8]);
                smp_rd++;
            end else begin
                exp_q.push_back('0);
                if (en && !rs) m_under = 1'b1;
            end
            exp_t.push_back(cyc + 1);
        end
        if (pend) begin
            ents.push_back(pend_val);
            ent_wr++;
            pend = 1'b0;
        end
        if (wr) begin
            if (ok_w) begin
                wbuf.push_back(wdata);
                acc_words++;
                if (wbuf.size() == 3) begin
                    pend_val = {wbuf[0], wbuf[1], wbuf[2]};
                    pend     = 1'b1;
                    wbuf.delete();
                end
            end else if (!rs) begin
                m_over = 1'b1;
            end
        end
        if (rs) clear_data();
        hist = {hist[1:0], sync};
    endtask

    initial begin
        clear_data();
        hist = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                clear_data();
                hist = '0;
                exp_q.delete();
                exp_t.delete();
            end else begin
                model_step();
            end
        end
    end

    // Scoreboard: compares every output on every falling edge out of reset.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("wready", int'(wready), int'(m_wready()));
                chk("switch", int'(sw), banks_read() % 2);
                chk("underrun", int'(underrun), int'(m_under));
                chk("overflow", int'(overflow), int'(m_over));
                if (exp_t.size() > 0 && exp_t[0] == cyc) begin
                    chk("dvalid", int'(dvalid), 1);
                    chk("dout", int'(dout), int'(exp_q[0]));
                    void'(exp_t.pop_front());
                    void'(exp_q.pop_front());
                end else begin
                    chk("dvalid_idle", int'(dvalid), 0);
                end
                if (dvalid) got_q.push_back(dout);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic put_word(input logic [15:0] w);
        wr    = 1'b1;
        wdata = w;
        tick();
        wr    = 1'b0;
    endtask

    task automatic req();
        sp_req = 1'b1;
        tick();
        sp_req = 1'b0;
    endtask

    task automatic pulse_sync();
        sync = 1'b1;
        tick();
        tick();
        sync = 1'b0;
    endtask

    logic [DW-1:0] bank0_exp [8];
    int            sync_cnt;
    int            k;

    initial begin
        bank0_exp[0] = 16'h0001; bank0_exp[1] = 16'h0200;
        bank0_exp[2] = 16'h0004; bank0_exp[3] = 16'h0500;
        bank0_exp[4] = 16'h0007; bank0_exp[5] = 16'h0800;
        bank0_exp[6] = 16'h000A; bank0_exp[7] = 16'h0B00;

        // Reset with enable already high: outputs must still read zero.
        en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout", int'(dout), 0);
        chk("rst_dvalid", int'(dvalid), 0);
        chk("rst_wready", int'(wready), 0);
        chk("rst_switch", int'(sw), 0);
        chk("rst_underrun", int'(underrun), 0);
        chk("rst_overflow", int'(overflow), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Fill both banks with 1..24, then a 25th word that must be dropped.
        for (int i = 1; i <= 12; i++) put_word(16'(i));
        chk("wready_bank0_full", int'(wready), 1);
        for (int i = 13; i <= 24; i++) put_word(16'(i));
        chk("wready_both_full", int'(wready), 0);
        put_word(16'h0019);
        chk("overflow_25th", int'(overflow), 1);
        tick();

        // Drain bank 0 with spaced requests.
        got_q.delete();
        for (int i = 0; i < 8; i++) begin
            req();
            tick();
            tick();
        end
        repeat (3) tick();
        chk("bank0_count", got_q.size(), 8);
        for (int i = 0; i < 8 && i < got_q.size(); i++) chk("bank0_sample", int'(got_q[i]), int'(bank0_exp[i]));
        chk("switch_after_bank0", int'(sw), 1);
        chk("wready_bank0_free", int'(wready), 1);
        chk("underrun_none", int'(underrun), 0);

        // Back-to-back requests: lane 0 then lane 1 of bank 1 entry 0.
        got_q.delete();
        sp_req = 1'b1;
        tick();
        tick();
        sp_req = 1'b0;
        repeat (3) tick();
        chk("b2b_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("b2b_lane0", int'(got_q[0]), 16'h000D);
            chk("b2b_lane1", int'(got_q[1]), 16'h0E00);
        end

        // Restart empties the cache; a request then underruns.
        pulse_sync();
        repeat (4) tick();
        chk("restart_overflow", int'(overflow), 0);
        chk("restart_switch", int'(sw), 0);
        got_q.delete();
        req();
        repeat (3) tick();
        chk("empty_count", got_q.size(), 1);
        if (got_q.size() == 1) chk("empty_dout", int'(got_q[0]), 0);
        chk("empty_underrun", int'(underrun), 1);
        sync = 1'b1;
        k = 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            sync = 1'b0;
            k = i;
            if (!underrun) break;
        end
        chk("underrun_clear_latency_ok", int'(k <= 4), 1);

        // Reset in the middle of packing an entry.
        req();
        repeat (3) tick();
        put_word(16'h1111);
        put_word(16'h2222);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_underrun", int'(underrun), 0);
        chk("midrst_wready", int'(wready), 0);
        chk("midrst_dvalid", int'(dvalid), 0);
        chk("midrst_dout", int'(dout), 0);
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 1; i <= 12; i++) put_word(16'h0A00 + 16'(i));
        tick();
        tick();
        got_q.delete();
        req();
        req();
        repeat (3) tick();
        chk("midrst_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("midrst_lane0", int'(got_q[0]), 16'h0A01);
            chk("midrst_lane1", int'(got_q[1]), 16'h020A);
        end

        // Random traffic: writer-heavy first half, reader-heavy second half.
        sync_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            en     = ($urandom_range(0, 19) != 0);
            wr     = $urandom_range(0, 1) == 1;
            wdata  = 16'($urandom);
            sp_req = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
            if (sync_cnt > 0) begin
                sync = 1'b1;
                sync_cnt--;
            end else begin
                sync = 1'b0;
                if ($urandom_range(0, 499) == 0) sync_cnt = 2;
            end
            tick();
        end
        wr     = 1'b0;
        sp_req = 1'b0;
        sync   = 1'b0;
        en     = 1'b1;
        repeat (5) tick();
        chk("drain", exp_t.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
